rc4_ksa_swap: RTL

//   RC4 key-scheduling (KSA) stage, second pass. For i = 0..255: j = j + S[i] + key[i mod 3], then swap S[i] and S[j].

---
 rtl/rc4_pkg.sv | 24 ++
 rtl/rc4_ksa_swap.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling blocks.
package rc4_pkg;

    localparam int KEY_LEN   = 3;
    localparam int SBOX_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WT_SI,
        KEY_REQ,
        KEY_WT,
        CALC_J,
        RD_SJ,
        WT_SJ,
        WR_SI,
        WR_SJ,
        NEXT,
        FIN
    } state_t;

endpackage

// File: rtl/rc4_ksa_swap.sv
// RC4 KSA swap pass: j += S[i] + key[i mod 3], swap S[i]/S[j] for i = 0..255.
// Optional KSA_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module rc4_ksa_swap
    import rc4_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              key_start,
    output logic [ADDR_W-1:0] key_i,
    input  logic              key_finish,
    input  logic [DATA_W-1:0] key_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef KSA_CYCLE_COUNT_EN
    ,
    output logic [15:0]       cycle_count
`endif
);

    localparam logic [1:0]        LAT_LAST = 2'(MEM_RD_LAT - 1);
    localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(SBOX_SIZE - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [DATA_W-1:0]   si_q, si_d;
    logic [DATA_W-1:0]   kb_q, kb_d;
    logic [1:0]          lat_q, lat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                key_start_q, key_start_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        kb_d    = kb_q;
        lat_d   = lat_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RD_SI;
                i_d     = '0;
                j_d     = '0;
            end
            RD_SI: begin
                state_d = WT_SI;
                lat_d   = '0;
            end
            WT_SI: if (lat_q == LAT_LAST) begin
                si_d    = mem_rdata;
                state_d = KEY_REQ;
            end else begin
                lat_d = lat_q + 2'd1;
            end
            KEY_REQ: state_d = KEY_WT;
            KEY_WT: if (key_finish) begin
                kb_d    = key_byte;
                state_d = CALC_J;
            end
            CALC_J: begin
                j_d     = j_q + ADDR_W'(si_q) + ADDR_W'(kb_q);
                state_d = RD_SJ;
            end
            RD_SJ: begin
                state_d = WT_SJ;
                lat_d   = '0;
            end
            // S[j] goes straight from the read port into the first write's data.
            WT_SJ: if (lat_q == LAT_LAST) begin
                mem_wdata_d = mem_rdata;
                state_d     = WR_SI;
            end else begin
                lat_d = lat_q + 2'd1;
            end
            WR_SI: begin
                mem_wdata_d = si_q;
                state_d     = WR_SJ;
            end
            WR_SJ: state_d = NEXT;
            NEXT: if (i_q == I_LAST) begin
                state_d = FIN;
            end else begin
                i_d     = i_q + 1'b1;
                state_d = RD_SI;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered and decoded from the state being entered.
        mem_addr_d = mem_addr_q;
        case (state_d)
            RD_SI:   mem_addr_d = i_d;
            RD_SJ:   mem_addr_d = j_d;
            WR_SI:   mem_addr_d = i_q;
            WR_SJ:   mem_addr_d = j_q;
            default: mem_addr_d = mem_addr_q;
        endcase
        busy_d      = (state_d != IDLE) && (state_d != FIN);
        done_d      = (state_d == FIN);
        key_start_d = (state_d == KEY_REQ);
        mem_wren_d  = (state_d == WR_SI) || (state_d == WR_SJ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            kb_q        <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_start_q <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            kb_q        <= kb_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_start_q <= key_start_d;
            mem_wren_q  <= mem_wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_start = key_start_q;
    assign key_i     = i_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

`ifdef KSA_CYCLE_COUNT_EN
    logic [15:0] cycle_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else if (state_q == IDLE && start) begin
            cycle_count_q <= '0;
        end else if (busy_q && cycle_count_q != 16'hFFFF) begin
            cycle_count_q <= cycle_count_q + 16'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule
